ff_and_checker: RTL and testbench
=================================

# ff_and_checker

Self-checking response monitor for the AND-gated flip-flop with active-low clear/preset. It receives the same stimulus the flip-flop sees (ip0, ip1, clear0, preset0), runs a cycle-accurate reference model, and compares the flip-flop's op0/op0bar every clock for a programmed window. The result is reported as a pass flag, an error count and the first failing cycle. It sits next to the flip-flop as the receiving end of its stimulus interface, so directed benches and on-chip self-test no longer rely on waveform inspection.

## Interface
- CHECK_LEN, 16: number of compare cycles per run (1..2^CNT_W-1)
- CNT_W, 8: width of error counter and cycle index
- EXP_ID, 20'h00000: expected value of the DUT identity bus
- clk  in  1  rising-edge clock, shared with DUT
- clear  in  1  reset, synchronous, active-high
- start  in  1  single-cycle run request
- dut_ip0, dut_ip1  in  1  DUT data inputs, as driven to DUT
- dut_clear0, dut_preset0  in  1  DUT active-low clear/preset, as driven to DUT
- dut_op0, dut_op0bar  in  1  DUT outputs
- dut_id_num  in  20  DUT identity bus
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- pass  out  1  run result; valid from done until next accepted start
- err_cnt  out  CNT_W  saturating mismatch count
- first_err_cyc  out  CNT_W  index of first mismatch; all-ones if none
- id_ok  out  1  identity check result

## Operation
- Reference model exp_q, updated every edge:
  - 0 if dut_clear0 = 0
  - else 1 if dut_preset0 = 0
  - else dut_ip0 & dut_ip1
  - Clear has priority over preset.
- Mismatch in a compare cycle: dut_op0 != exp_q, or dut_op0bar != ~dut_op0.
- Compare is masked in a cycle if dut_clear0 or dut_preset0 was sampled low at this edge or the previous edge.
- Async pulses that fall entirely between edges are not modelled. Stimulus must hold clear0/preset0 low across an edge for them to be checked.
- FSM states:
  - IDLE: start=1 goes to WARM. On entry to WARM, err_cnt, first_err_cyc (all-ones), pass and id_ok are re-initialised, and busy rises.
  - WARM: one cycle. Model loads from sampled inputs, no compare. Goes to CHECK.
  - CHECK: exactly CHECK_LEN compare cycles, index 0..CHECK_LEN-1. Goes to DONE after the last one.
  - DONE: one cycle. done=1, busy=0, pass = (err_cnt==0) & id_ok. Goes to IDLE.
- start while busy or in DONE is ignored.
- err_cnt saturates at 2^CNT_W-1 and never wraps.
- first_err_cyc is written only on the first mismatch of a run.
- Results hold in IDLE until the next accepted start.

## Timing
- Reset values (clear=1, synchronous, takes priority over everything): state IDLE, busy=0, done=0, pass=0, err_cnt=0, first_err_cyc=all-ones, id_ok=0, exp_q=0.
- clear mid-run aborts to IDLE at the next edge with reset values; no done pulse.
- Latency:
  - start sampled at edge T.
  - busy=1 from T+1.
  - compare cycles at edges T+2..T+1+CHECK_LEN.
  - done=1 during cycle T+2+CHECK_LEN.
  - Total run = CHECK_LEN+2 cycles.
- Compare at edge k uses dut_op0 sampled at k against exp_q registered at edge k-1.
- start coincident with the final DONE cycle is ignored. A new start is accepted from the first IDLE cycle.

## Configuration
- FF_CHK_ID_EN defined: dut_id_num is captured at the edge start is accepted; id_ok = (captured == EXP_ID), valid from WARM onward.
- FF_CHK_ID_EN undefined: dut_id_num is unused, id_ok is forced to 1 after any accepted start, and pass depends on err_cnt alone.

## Test plan
- Reset then idle: clear=1 for 2 cycles -> busy=0, done=0, err_cnt=0, first_err_cyc=8'hFF.
- Correct DUT, CHECK_LEN=16, random ip0/ip1, clear0=preset0=1 -> done exactly 18 cycles after start, err_cnt=0, pass=1.
- Faulty DUT (op0 stuck at 0), ip0=ip1=1 held -> first_err_cyc=0, err_cnt=16, pass=0.
- op0bar forced equal to op0 at compare index 5 only -> err_cnt=1, first_err_cyc=5.
- clear0 low across one edge during run -> no mismatch in the masked cycles, exp_q=0 afterwards, err_cnt=0 for a correct DUT. A second start while busy -> ignored, done pulses once.
- clear=1 at compare index 7 -> returns to IDLE with reset values, no done. With FF_CHK_ID_EN and dut_id_num != EXP_ID -> id_ok=0, pass=0 despite err_cnt=0.

Source files
------------

// File: rtl/ff_and_checker_if.sv
// Stimulus/response bundle between the AND-gated flip-flop test driver
// (master) and the ff_and_checker monitor (slave).
interface ff_and_checker_if #(
  parameter int CNT_W = 8
);
  // run control
  logic             start;
  // stimulus as driven to the flip-flop, and its responses
  logic             dut_ip0;
  logic             dut_ip1;
  logic             dut_clear0;
  logic             dut_preset0;
  logic             dut_op0;
  logic             dut_op0bar;
  logic [19:0]      dut_id_num;
  // run status and results
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] first_err_cyc;
  logic             id_ok;

  modport master (
    output start, dut_ip0, dut_ip1, dut_clear0, dut_preset0,
           dut_op0, dut_op0bar, dut_id_num,
    input  busy, done, pass, err_cnt, first_err_cyc, id_ok
  );

  modport slave (
    input  start, dut_ip0, dut_ip1, dut_clear0, dut_preset0,
           dut_op0, dut_op0bar, dut_id_num,
    output busy, done, pass, err_cnt, first_err_cyc, id_ok
  );
endinterface

// File: rtl/ff_and_checker.sv
// Response monitor for the AND-gated flip-flop with active-low clear/preset.
// Runs a cycle-accurate reference of the flop and compares op0/op0bar for
// CHECK_LEN cycles per run; reports pass, a saturating error count and the
// index of the first failing compare.
// Optional feature macro: FF_CHK_ID_EN -- when defined, dut_id_num is
// captured on an accepted start and checked against EXP_ID; otherwise
// id_ok is forced high after any accepted start.
module ff_and_checker #(
  parameter int          CHECK_LEN = 16,
  parameter int          CNT_W     = 8,
  parameter logic [19:0] EXP_ID    = 20'h00000
) (
  input  logic             clk,
  input  logic             clear,
  ff_and_checker_if.slave  bus
);

  localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(CHECK_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, WARM, CHECK, DONE} state_t;

  state_t           state_q, state_d;
  logic             exp_q, exp_d;
  logic             prev_lo_q, prev_lo_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] first_err_q, first_err_d;
  logic             pass_q, pass_d;
  logic             id_ok_q, id_ok_d;

  logic             cur_lo;
  logic             mask;
  logic             mismatch;
  logic             id_match;

`ifdef FF_CHK_ID_EN
  assign id_match = (bus.dut_id_num == EXP_ID);
`else
  assign id_match = 1'b1;
`endif

  // State register; clear aborts any run straight back to IDLE.
  always_ff @(posedge clk) begin
    if (clear) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: IDLE -> WARM (1) -> CHECK (CHECK_LEN) -> DONE (1) -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = WARM;
      WARM:    state_d = CHECK;
      CHECK:   if (idx_q == IDX_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: reference flop, compare masking, result counters.
  always_comb begin
    // Async clear/preset on the flop make the edge where they are sampled
    // low, and the edge after, unpredictable for a clocked model.
    cur_lo   = ~bus.dut_clear0 | ~bus.dut_preset0;
    mask     = cur_lo | prev_lo_q;
    mismatch = (bus.dut_op0 != exp_q) | (bus.dut_op0bar != ~bus.dut_op0);

    exp_d       = ~bus.dut_clear0 ? 1'b0 :
                  ~bus.dut_preset0 ? 1'b1 : (bus.dut_ip0 & bus.dut_ip1);
    prev_lo_d   = cur_lo;
    idx_d       = idx_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    pass_d      = pass_q;
    id_ok_d     = id_ok_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          idx_d       = '0;
          err_cnt_d   = '0;
          first_err_d = CNT_MAX;
          pass_d      = 1'b0;
          id_ok_d     = id_match;
        end
      end
      CHECK: begin
        if (mismatch && !mask) begin
          // err_cnt only leaves zero on the first mismatch and never wraps,
          // so a zero count identifies the first failure of the run.
          if (err_cnt_q == '0)      first_err_d = idx_q;
          if (err_cnt_q != CNT_MAX) err_cnt_d   = err_cnt_q + 1'b1;
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_LAST) pass_d = (err_cnt_d == '0) & id_ok_q;
      end
      default: ;
    endcase
  end

  // Datapath registers; clear restores every result to its idle value.
  always_ff @(posedge clk) begin
    if (clear) begin
      exp_q       <= 1'b0;
      prev_lo_q   <= 1'b0;
      idx_q       <= '0;
      err_cnt_q   <= '0;
      first_err_q <= CNT_MAX;
      pass_q      <= 1'b0;
      id_ok_q     <= 1'b0;
    end else begin
      exp_q       <= exp_d;
      prev_lo_q   <= prev_lo_d;
      idx_q       <= idx_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      pass_q      <= pass_d;
      id_ok_q     <= id_ok_d;
    end
  end

  // Outputs: status decoded from state, results straight from registers.
  always_comb begin
    bus.busy          = (state_q == WARM) || (state_q == CHECK);
    bus.done          = (state_q == DONE);
    bus.pass          = pass_q;
    bus.err_cnt       = err_cnt_q;
    bus.first_err_cyc = first_err_q;
    bus.id_ok         = id_ok_q;
  end

endmodule

// File: tb/tb_ff_and_checker.sv
module tb_ff_and_checker;
  localparam int          L     = 16;
  localparam int          CW    = 8;
  localparam logic [19:0] EID   = 20'h00000;
  localparam int          MAXV  = (1 << CW) - 1;

  logic clk;
  logic clear;
  ff_and_checker_if #(.CNT_W(CW)) bus();

  ff_and_checker #(.CHECK_LEN(L), .CNT_W(CW), .EXP_ID(EID)) dut (
    .clk(clk), .clear(clear), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural flip-flop driving the monitor's response inputs, with faults.
  logic ff_q = 1'b0;
  logic stuck0 = 1'b0;
  logic bar_bad = 1'b0;
  logic op_true;
  always @(posedge clk)
    ff_q <= !bus.dut_clear0 ? 1'b0 : !bus.dut_preset0 ? 1'b1 : (bus.dut_ip0 & bus.dut_ip1);
  assign op_true        = !bus.dut_clear0 ? 1'b0 : !bus.dut_preset0 ? 1'b1 : ff_q;
  assign bus.dut_op0    = stuck0 ? 1'b0 : op_true;
  assign bus.dut_op0bar = bar_bad ? bus.dut_op0 : ~bus.dut_op0;

  // Run-offset model: m_off counts edges since the accepted start.
  int m_off = -1, m_err = 0, m_fec = MAXV;
  bit m_pass = 0, m_id = 0, m_exp = 0, m_lo_prev = 0;
  always @(posedge clk) begin
    bit c0, p0, lo;
    c0 = bus.dut_clear0; p0 = bus.dut_preset0;
    lo = !c0 || !p0;
    if (clear) begin
      m_off = -1; m_err = 0; m_fec = MAXV; m_pass = 0; m_id = 0;
      m_exp = 0; m_lo_prev = 0;
    end else begin
      if (m_off >= 0) begin
        m_off++;
        if (m_off >= 2 && m_off <= L + 1) begin
          if (!(lo || m_lo_prev) &&
              (bus.dut_op0 !== m_exp || bus.dut_op0bar !== !bus.dut_op0)) begin
            if (m_err == 0) m_fec = m_off - 2;
            if (m_err < MAXV) m_err++;
          end
          if (m_off == L + 1) m_pass = (m_err == 0) && m_id;
        end else if (m_off == L + 2) m_off = -1;
      end else if (bus.start) begin
        m_off = 0; m_err = 0; m_fec = MAXV; m_pass = 0;
`ifdef FF_CHK_ID_EN
        m_id = (bus.dut_id_num == EID);
`else
        m_id = 1;
`endif
      end
      m_exp = !c0 ? 1'b0 : !p0 ? 1'b1 : (bus.dut_ip0 & bus.dut_ip1);
      m_lo_prev = lo;
    end
    #1;
    chk("busy",  bus.busy,  (m_off >= 0 && m_off <= L));
    chk("done",  bus.done,  (m_off == L + 1));
    chk("pass",  bus.pass,  m_pass);
    chk("err_cnt", bus.err_cnt, m_err);
    chk("first_err_cyc", bus.first_err_cyc, m_fec);
    chk("id_ok", bus.id_ok, m_id);
  end

  bit rnd = 0;
  task automatic tick();
    @(negedge clk);
    if (rnd) begin
      bus.dut_ip0 = 1'($urandom);
      bus.dut_ip1 = 1'($urandom);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Pulse start; returns at the negedge after the edge that sampled it.
  task automatic go();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.done && lat < 60) begin tick(); lat++; end
    chk("done_seen", bus.done, 1'b1);
  endtask

  int lat, pulses;

  initial begin
    clear = 1'b1; bus.start = 1'b0;
    bus.dut_ip0 = 1'b0; bus.dut_ip1 = 1'b0;
    bus.dut_clear0 = 1'b1; bus.dut_preset0 = 1'b1;
    bus.dut_id_num = EID;

    // reset then idle
    ticks(2);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err",  bus.err_cnt, 0);
    chk("rst_fec",  bus.first_err_cyc, 8'hFF);
    chk("rst_pass", bus.pass, 0);
    clear = 1'b0;
    ticks(2);

    // correct DUT, random data, latency from start assertion
    rnd = 1;
    go();
    lat = 1;
    while (!bus.done && lat < 60) begin tick(); lat++; end
    chk("latency", lat, 18);
    chk("good_err",  bus.err_cnt, 0);
    chk("good_pass", bus.pass, 1);
    chk("good_fec",  bus.first_err_cyc, 8'hFF);
    tick();
    chk("hold_pass", bus.pass, 1);

    // op0 stuck at 0 with both data inputs high
    rnd = 0; bus.dut_ip0 = 1'b1; bus.dut_ip1 = 1'b1; stuck0 = 1'b1;
    ticks(2);
    go();
    wait_done(lat);
    chk("stuck_fec",  bus.first_err_cyc, 0);
    chk("stuck_err",  bus.err_cnt, 16);
    chk("stuck_pass", bus.pass, 0);
    stuck0 = 1'b0;
    ticks(2);

    // op0bar equals op0 at compare index 5 only
    rnd = 1;
    go();
    ticks(6);
    bar_bad = 1'b1;
    tick();
    bar_bad = 1'b0;
    wait_done(lat);
    chk("bar_err",  bus.err_cnt, 1);
    chk("bar_fec",  bus.first_err_cyc, 5);
    chk("bar_pass", bus.pass, 0);
    ticks(2);

    // clear0 low across one edge mid-run, plus a start while busy
    rnd = 0; bus.dut_ip0 = 1'b1; bus.dut_ip1 = 1'b1;
    tick();
    go();
    ticks(5);
    bus.dut_clear0 = 1'b0;
    tick();
    bus.dut_clear0 = 1'b1;
    ticks(3);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.done) pulses++;
      tick();
    end
    chk("clr0_done_pulses", pulses, 1);
    chk("clr0_err",  bus.err_cnt, 0);
    chk("clr0_pass", bus.pass, 1);

    // preset0 low across an edge in a run: masked, no errors
    bus.dut_ip0 = 1'b0;
    go();
    ticks(4);
    bus.dut_preset0 = 1'b0;
    tick();
    bus.dut_preset0 = 1'b1;
    wait_done(lat);
    chk("pre0_err", bus.err_cnt, 0);
    ticks(2);

    // clear at compare index 7 aborts the run
    rnd = 1;
    go();
    ticks(8);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_fec",  bus.first_err_cyc, 8'hFF);
    chk("abort_pass", bus.pass, 0);
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus.done) pulses++;
      tick();
    end
    chk("abort_no_done", pulses, 0);

    // identity mismatch
    bus.dut_id_num = 20'h00001;
    go();
    wait_done(lat);
    chk("id_err", bus.err_cnt, 0);
`ifdef FF_CHK_ID_EN
    chk("id_ok_bad",  bus.id_ok, 0);
    chk("id_pass",    bus.pass, 0);
`else
    chk("id_ok_forced", bus.id_ok, 1);
    chk("id_pass",      bus.pass, 1);
`endif
    bus.dut_id_num = EID;
    ticks(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
